// File: rtl/i2s_tdm_tx_if.sv
// Write-side handshake bundle for i2s_tdm_tx.
// The producer drives wr_valid/wr_data. The transmitter answers with wr_ready, meaning its FIFO is not full.
interface i2s_tdm_tx_if #(
    parameter int DATA_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: N-channel serial audio master transmitter (I2S / left-justified / TDM framing).
//
// Words arrive through a valid/ready FIFO. A whole frame of CHANNELS words is popped into a
// shadow buffer at every frame start. Bits are then shifted out on sd, MSB first.
// sclk is a registered divided clock. sd and ws only change in the pclk cycle where sclk falls.
//
// When tran_en is raised from idle, sclk produces one lead-in pulse with ws=sd=0. The first frame
// is loaded at the falling edge of that pulse.
//
// TDM sync is driven high during the last bit of every frame. Back-to-back frames therefore see the
// sync one bit before slot 0. The very first frame after idle has no preceding sync bit.
//
// Optional feature, controlled by macro I2S_TX_REPEAT_ON_UNDERRUN_EN:
//   defined   - an underrun frame repeats the previous shadow words (zeros if none since reset)
//   undefined - an underrun frame is all zeros
module i2s_tdm_tx #(
    parameter int DATA_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        tran_en,
    input  logic [1:0]                  mode,
    input  logic [$clog2(DATA_W)-1:0]   word_size,
    input  logic [$clog2(DATA_W)-1:0]   slot_size,
    input  logic [DIV_W-1:0]            clk_div,
    i2s_tdm_tx_if.slave                 wr,
    output logic                        sclk,
    output logic                        ws,
    output logic                        sd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun
);
    localparam int SZ_W   = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int SLOT_W = $clog2(CHANNELS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(CHANNELS / 2);
    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_TDM = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic              sclk_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] shadow_reg [CHANNELS];
    logic [DATA_W-1:0] fifo_word [CHANNELS];
    logic [DATA_W-1:0] load_word [CHANNELS];
    logic [1:0]        mode_reg;
    logic [SZ_W-1:0]   wsz_reg, ssz_reg, bit_cnt_reg, nxt_bit;
    logic [SLOT_W-1:0] slot_cnt_reg, nxt_slot;
    logic              ws_reg, sd_reg, prev_bit_reg, underrun_reg;
    logic              nxt_data, nxt_ws, load_bit;

    // The bit clock only runs while a transfer is requested or still finishing.
    wire clk_run      = (state_reg != ST_IDLE) || tran_en;
    wire div_wrap     = div_cnt_reg >= clk_div;
    wire fall_tick    = clk_run && div_wrap && sclk_reg;
    wire enough       = level_reg >= LVL_W'(CHANNELS);
    wire at_last_bit  = bit_cnt_reg == ssz_reg;
    wire at_frame_end = (state_reg == ST_RUN) && at_last_bit && (slot_cnt_reg == LAST_SLOT);
    wire do_load      = fall_tick && tran_en && ((state_reg == ST_IDLE) || at_frame_end);
    wire pop          = do_load && enough;
    wire wr_fire      = wr.wr_valid && wr.wr_ready;

    // Returns the bit sent at position b of a slot: word bits wsz..0 MSB first, then zero padding.
    function automatic logic pick_bit(input logic [DATA_W-1:0] w,
                                      input logic [SZ_W-1:0] wsz,
                                      input logic [SZ_W-1:0] b);
        if (b > wsz) return 1'b0;
        return w[wsz - b];
    endfunction

    // The frame is read straight from the FIFO. On underrun it falls back to the repeat or zero policy.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_frame
            assign fifo_word[gi] = mem[rd_ptr_reg + PTR_W'(gi)];
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            assign load_word[gi] = enough ? fifo_word[gi] : shadow_reg[gi];
`else
            assign load_word[gi] = enough ? fifo_word[gi] : '0;
`endif
        end
    endgenerate

    assign level_next = level_reg + LVL_W'(wr_fire) - (pop ? LVL_W'(CHANNELS) : LVL_W'(0));
    assign load_bit   = load_word[0][word_size];

    // Position that follows the current one inside a running frame.
    always_comb begin
        nxt_bit  = at_last_bit ? '0 : bit_cnt_reg + SZ_W'(1);
        nxt_slot = at_last_bit ? slot_cnt_reg + SLOT_W'(1) : slot_cnt_reg;
        nxt_data = pick_bit(shadow_reg[nxt_slot], wsz_reg, nxt_bit);
        if (mode_reg == MODE_TDM)
            nxt_ws = (nxt_bit == ssz_reg) && (nxt_slot == LAST_SLOT);
        else
            nxt_ws = nxt_slot >= HALF_SLOT;
    end

    // Bit-clock divider: toggle sclk every clk_div+1 pclk cycles. Park it low when idle.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (!clk_run) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt_reg <= '0;
            sclk_reg    <= ~sclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // FIFO storage: no reset; contents are invalidated by clearing the pointers.
    always_ff @(posedge pclk) begin
        if (wr_fire) mem[wr_ptr_reg] <= wr.wr_data;
    end

    // FIFO pointers and fill level. A frame load pops CHANNELS words at once.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(CHANNELS);
            level_reg <= level_next;
        end
    end

    // Frame sequencer: loads frames, walks bit/slot counters and drives ws/sd at each sclk fall.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= '0;
            wsz_reg      <= '0;
            ssz_reg      <= '0;
            bit_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
            ws_reg       <= 1'b0;
            sd_reg       <= 1'b0;
            prev_bit_reg <= 1'b0;
            underrun_reg <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) shadow_reg[i] <= '0;
        end else begin
            underrun_reg <= 1'b0;
            if (do_load) begin
                state_reg    <= ST_RUN;
                mode_reg     <= mode;
                wsz_reg      <= word_size;
                ssz_reg      <= slot_size;
                bit_cnt_reg  <= '0;
                slot_cnt_reg <= '0;
                underrun_reg <= !enough;
                for (int i = 0; i < CHANNELS; i++) shadow_reg[i] <= load_word[i];
                ws_reg       <= 1'b0;
                // I2S emits the previous frame's final bit here, so data trails ws by one sclk.
                sd_reg       <= (mode == MODE_I2S) ? prev_bit_reg : load_bit;
                prev_bit_reg <= load_bit;
            end else if (fall_tick) begin
                case (state_reg)
                    ST_RUN: begin
                        if (at_frame_end) begin
                            state_reg    <= ST_STOP;
                            ws_reg       <= 1'b0;
                            sd_reg       <= (mode_reg == MODE_I2S) ? prev_bit_reg : 1'b0;
                            prev_bit_reg <= 1'b0;
                        end else begin
                            bit_cnt_reg  <= nxt_bit;
                            slot_cnt_reg <= nxt_slot;
                            ws_reg       <= nxt_ws;
                            sd_reg       <= (mode_reg == MODE_I2S) ? prev_bit_reg : nxt_data;
                            prev_bit_reg <= nxt_data;
                        end
                    end
                    ST_STOP: begin
                        state_reg <= ST_IDLE;
                        ws_reg    <= 1'b0;
                        sd_reg    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sclk        = sclk_reg;
    assign ws          = ws_reg;
    assign sd          = sd_reg;
    assign underrun    = underrun_reg;
    assign fifo_level  = level_reg;
    assign wr.wr_ready = level_reg != LVL_W'(FIFO_DEPTH);
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Testbench for i2s_tdm_tx (CHANNELS=4, DEPTH=8).
// Expected serial streams are derived from word lists and framing rules. A monitor compares every
// received bit, taken at the sclk rising edge.
module tb_i2s_tdm_tx;
    localparam int DW = 32, CH = 4, FD = 8, DVW = 8;

    logic       pclk = 1'b0, preset = 1'b0, tran_en = 1'b0;
    logic [1:0] mode = '0;
    logic [4:0] word_size = '0, slot_size = '0;
    logic [7:0] clk_div = '0;
    logic       sclk, ws, sd, underrun;
    logic [3:0] fifo_level;

    i2s_tdm_tx_if #(.DATA_W(DW)) wif ();

    i2s_tdm_tx #(.DATA_W(DW), .CHANNELS(CH), .FIFO_DEPTH(FD), .DIV_W(DVW)) dut (
        .pclk(pclk), .preset(preset), .tran_en(tran_en), .mode(mode),
        .word_size(word_size), .slot_size(slot_size), .clk_div(clk_div),
        .wr(wif), .sclk(sclk), .ws(ws), .sd(sd),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    typedef struct packed { logic ws; logic sd; } pos_t;

    int          n_cmp = 0, n_bad = 0;
    pos_t        exp_q[$];
    pos_t        mon_e;
    logic        cap_sd[$], cap_ws[$];
    logic [31:0] mfifo[$];
    logic [31:0] mprev[CH];
    int          rise_cnt = 0, under_cnt = 0, run_div = 0;
    longint      cyc = 0, last_rise = -1;
    logic        p_sclk = 1'b0, p_ws = 1'b0, p_sd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Receiver-side monitor: checks every sclk rise, the pacing of sd/ws changes and the underrun pulses.
    always @(negedge pclk) begin
        cyc++;
        if (preset) begin
            if (sclk === 1'b1 && p_sclk === 1'b0) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_bit: sclk rise %0d with nothing expected (ws=%b sd=%b)", rise_cnt, ws, sd);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("ws_bit%0d", rise_cnt), ws, mon_e.ws);
                    chk($sformatf("sd_bit%0d", rise_cnt), sd, mon_e.sd);
                    cap_ws.push_back(ws);
                    cap_sd.push_back(sd);
                end
                if (last_rise >= 0) chk("sclk_period", cyc - last_rise, 2 * (run_div + 1));
                last_rise = cyc;
            end
            if ((ws !== p_ws || sd !== p_sd) && !(p_sclk === 1'b1 && sclk === 1'b0)) begin
                n_cmp++; n_bad++;
                $display("FAIL edge: ws %b->%b sd %b->%b without sclk fall", p_ws, ws, p_sd, sd);
            end
            if (underrun === 1'b1) under_cnt++;
        end
        p_sclk = sclk; p_ws = ws; p_sd = sd;
    end

    // Builds the expected receiver stream for nf frames, popping the model FIFO as the frames load.
    task automatic build(input logic [1:0] md, input int wsz, input int ssz, input int nf,
                         output int n_under, output int lvl_first);
        logic        d[$];
        logic        w[$];
        logic [31:0] fr[CH];
        pos_t        p;
        n_under = 0; lvl_first = 0;
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            if (mfifo.size() >= CH) begin
                for (int s = 0; s < CH; s++) begin fr[s] = mfifo.pop_front(); mprev[s] = fr[s]; end
            end else begin
                n_under++;
                for (int s = 0; s < CH; s++) begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    fr[s] = mprev[s];
`else
                    fr[s] = '0;
`endif
                end
            end
            if (f == 0) lvl_first = mfifo.size();
            for (int s = 0; s < CH; s++)
                for (int b = 0; b <= ssz; b++) begin
                    d.push_back(b <= wsz ? fr[s][wsz - b] : 1'b0);
                    w.push_back(md == 2'd2 ? (s == CH - 1 && b == ssz) : (s >= CH / 2));
                end
        end
        p.ws = 1'b0; p.sd = 1'b0;
        exp_q.push_back(p);                      // lead-in pulse from idle
        for (int k = 0; k < d.size(); k++) begin
            p.ws = w[k];
            p.sd = (md == 2'd0) ? (k == 0 ? 1'b0 : d[k-1]) : d[k];
            exp_q.push_back(p);
        end
        p.ws = 1'b0;
        p.sd = (md == 2'd0) ? d[d.size()-1] : 1'b0;
        exp_q.push_back(p);                      // stop bit (carries the I2S spill)
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge pclk); wif.wr_valid = 1'b1; wif.wr_data = w;
        @(negedge pclk); wif.wr_valid = 1'b0;
        mfifo.push_back(w);
    endtask

    task automatic do_reset();
        preset = 1'b0; tran_en = 1'b0; wif.wr_valid = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b1;
        mfifo.delete();
        for (int s = 0; s < CH; s++) mprev[s] = '0;
        @(negedge pclk);
    endtask

    task automatic run(input logic [1:0] md, input int wsz, input int ssz, input int dv, input int nf);
        int nu, lf, fb, drop, budget, waited;
        bit seen_first;
        @(negedge pclk);
        mode = md; word_size = 5'(wsz); slot_size = 5'(ssz); clk_div = 8'(dv);
        build(md, wsz, ssz, nf, nu, lf);
        cap_sd.delete(); cap_ws.delete();
        rise_cnt = 0; under_cnt = 0; last_rise = -1; run_div = dv;
        fb = CH * (ssz + 1);
        drop = (nf - 1) * fb + 5;                // inside the last frame, slot0 bit3
        budget = (nf * fb + 3) * 2 * (dv + 1) + 50;
        waited = 0; seen_first = 0;
        tran_en = 1'b1;
        while (exp_q.size() > 0 && waited < budget) begin
            @(negedge pclk); waited++;
            if (!seen_first && rise_cnt >= 2) begin
                seen_first = 1;
                chk("level_after_load", fifo_level, lf);
            end
            if (tran_en && rise_cnt >= drop) tran_en = 1'b0;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: %0d expected bits never seen", exp_q.size());
            exp_q.delete();
        end
        tran_en = 1'b0;
        repeat (4 * (dv + 1) + 8) @(negedge pclk);
        chk("idle_sclk", sclk, 0); chk("idle_ws", ws, 0); chk("idle_sd", sd, 0);
        chk("underrun_pulses", under_cnt, nu);
        chk("level_after_run", fifo_level, mfifo.size());
        $display("run mode=%0d word=%0d slot=%0d div=%0d frames=%0d underruns=%0d bits=%0d", md, wsz, ssz, dv, nf, nu, cap_sd.size());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wv;
        int nw, wsz, ssz;
        wif.wr_valid = 1'b0; wif.wr_data = '0;
        repeat (3) @(negedge pclk);
        chk("rst_sclk", sclk, 0); chk("rst_ws", ws, 0); chk("rst_sd", sd, 0);
        chk("rst_underrun", underrun, 0); chk("rst_level", fifo_level, 0); chk("rst_ready", wif.wr_ready, 1);
        preset = 1'b1;
        for (int s = 0; s < CH; s++) mprev[s] = '0;
        @(negedge pclk);

        // Left-justified, 16-bit words in 16-bit slots, sclk = pclk/4.
        push_word(32'h0000A5F0); push_word(32'h00000F0F); push_word(32'h00001234); push_word(32'h0000BEEF);
        run(2'd1, 15, 15, 1, 1);
        chk("lj_bits", cap_sd.size(), 66);
        wv = '0; for (int i = 1; i <= 16; i++) wv = {wv[14:0], cap_sd[i]};
        chk("lj_word0", wv, 16'hA5F0);
        wv = '0; for (int i = 17; i <= 32; i++) wv = {wv[14:0], cap_sd[i]};
        chk("lj_word1", wv, 16'h0F0F);
        chk("lj_ws_slot1_last", cap_ws[32], 0); chk("lj_ws_slot2_first", cap_ws[33], 1);

        // I2S: same words, data one sclk behind ws, LSB of last word spills past the frame.
        push_word(32'h0000A5F0); push_word(32'h00000F0F); push_word(32'h00001234); push_word(32'h0000BEEF);
        run(2'd0, 15, 15, 1, 1);
        chk("i2s_first_bit", cap_sd[1], 0);
        wv = '0; for (int i = 2; i <= 17; i++) wv = {wv[14:0], cap_sd[i]};
        chk("i2s_word0", wv, 16'hA5F0);
        chk("i2s_ws_edge", cap_ws[33], 1); chk("i2s_word1_lsb", cap_sd[33], 1);
        chk("i2s_spill", cap_sd[65], 1); chk("i2s_spill_ws", cap_ws[65], 0);

        // TDM: 24-bit words in 32-bit slots, sync in the frame's last bit.
        push_word(32'hFF800001); push_word($urandom); push_word($urandom); push_word($urandom);
        run(2'd2, 23, 31, 0, 1);
        chk("tdm_bits", cap_sd.size(), 130);
        chk("tdm_ws_first", cap_ws[1], 0); chk("tdm_ws_pre", cap_ws[127], 0); chk("tdm_ws_sync", cap_ws[128], 1);
        chk("tdm_msb", cap_sd[1], 1); chk("tdm_bit22", cap_sd[2], 0);
        chk("tdm_lsb", cap_sd[24], 1); chk("tdm_pad", cap_sd[25], 0);

        // FIFO full: the 9th word is held off, then two frames drain it.
        do_reset();
        for (int i = 0; i < FD; i++) push_word($urandom);
        @(negedge pclk); wif.wr_valid = 1'b1; wif.wr_data = 32'hDEADBEEF;
        @(negedge pclk);
        chk("full_ready", wif.wr_ready, 0); chk("full_level", fifo_level, 8);
        repeat (3) @(negedge pclk);
        wif.wr_valid = 1'b0;
        @(negedge pclk);
        chk("full_level_hold", fifo_level, 8);
        run(2'($urandom_range(0, 3)), 7, 7, 0, 2);
        chk("drained_level", fifo_level, 0);

        // Underrun: one word only; frame is zeros or a repeat, the word stays.
        push_word($urandom);
        run(2'd1, 7, 7, 0, 1);
        chk("underrun_once", under_cnt, 1); chk("underrun_level", fifo_level, 1);

        // Randomised configurations, fill levels and frame counts.
        for (int it = 0; it < 5; it++) begin
            do_reset();
            nw = $urandom_range(0, 8);
            for (int i = 0; i < nw; i++) push_word($urandom);
            wsz = $urandom_range(0, 31);
            ssz = $urandom_range(wsz < 7 ? 7 : wsz, 31);
            run(2'($urandom_range(0, 3)), wsz, ssz, $urandom_range(0, 2), $urandom_range(1, 3));
        end

        // Asynchronous reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < CH; i++) push_word($urandom);
        mode = 2'd1; word_size = 5'd15; slot_size = 5'd15; clk_div = 8'd1;
        begin
            int nu, lf, waited;
            build(2'd1, 15, 15, 1, nu, lf);
            rise_cnt = 0; last_rise = -1; run_div = 1; waited = 0;
            tran_en = 1'b1;
            while (rise_cnt < 10 && waited < 200) begin @(negedge pclk); waited++; end
            chk("midrst_reached", rise_cnt >= 10, 1);
        end
        @(posedge pclk); #2;
        preset = 1'b0;
        #1;
        chk("midrst_sclk", sclk, 0); chk("midrst_ws", ws, 0); chk("midrst_sd", sd, 0);
        chk("midrst_underrun", underrun, 0); chk("midrst_level", fifo_level, 0); chk("midrst_ready", wif.wr_ready, 1);
        exp_q.delete();
        tran_en = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b1;
        repeat (6) @(negedge pclk);
        chk("postrst_level", fifo_level, 0); chk("postrst_sclk", sclk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
